rng_axis_rx: RTL

//  AXI-Stream receiver (slave) for the 32-bit TRNG word stream with TLAST framing.

---
 rtl/rng_axis_rx.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/rng_axis_rx.sv
// rng_axis_rx: AXI-Stream slave for the 32-bit TRNG word stream.
// Accepts words under back-pressure, checks TLAST framing against PKT_BYTES,
// keeps byte/packet/sum statistics and buffers words in a small FWFT FIFO.
// Optional feature macro: RNG_RX_ONES_EN (enables the ONES_COUNT popcount).
module rng_axis_rx #(
  parameter int BUF_DEPTH = 4,
  parameter int PKT_W     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [31:0]      S_AXIS_TDATA,
  input  logic             S_AXIS_TLAST,
  input  logic             S_AXIS_TVALID,
  output logic             S_AXIS_TREADY,
  input  logic             GO,
  input  logic             STOP,
  input  logic [31:0]      PKT_BYTES,
  input  logic [31:0]      TOTAL_BYTES,
  output logic             RUN,
  output logic             DONE,
  output logic             ERR_LAST,
  output logic [31:0]      RECV_BYTES,
  output logic [PKT_W-1:0] PKT_COUNT,
  output logic [31:0]      SUM_DATA,
  output logic [31:0]      ONES_COUNT,
  output logic [31:0]      OUT_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY
);

  localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
  localparam logic [31:0] SAT_C = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_DONE} state_t;

  state_t state_q, state_d;

  logic [31:0]      recv_bytes_q, recv_bytes_d;
  logic [31:0]      sum_q, sum_d;
  logic [31:0]      pkt_bytes_q, pkt_bytes_d;
  logic [PKT_W-1:0] pkt_count_q, pkt_count_d;
  logic             err_q, err_d;

  logic [31:0]      mem_q [BUF_DEPTH];
  logic [31:0]      mem_d [BUF_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic        tready;
  logic        accept;
  logic        go_start;
  logic        push;
  logic        pop;
  logic        out_valid;
  logic [31:0] pkt_plus4;
  logic        last_err;

  // GO only restarts from IDLE/DONE, and STOP always overrides it
  assign go_start  = GO & ~STOP & (state_q != ST_RECV);
  assign accept    = S_AXIS_TVALID & tready;
  assign out_valid = (count_q != '0);
  assign push      = accept & ~STOP;
  assign pop       = out_valid & OUT_READY & ~STOP;
  assign pkt_plus4 = pkt_bytes_q + 32'd4;
  assign last_err  = (PKT_BYTES != 32'd0) &&
                     (S_AXIS_TLAST ? (pkt_plus4 != PKT_BYTES) : (pkt_plus4 == PKT_BYTES));

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; STOP beats everything else
  always_comb begin
    state_d = state_q;
    if (STOP) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (GO) state_d = ST_RECV;
        ST_RECV: if (accept && (TOTAL_BYTES != 32'd0) && (recv_bytes_d >= TOTAL_BYTES))
                   state_d = ST_DONE;
        ST_DONE: if (GO) state_d = ST_RECV;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs decoded from registered state only (no path from OUT_READY to TREADY)
  always_comb begin
    RUN    = (state_q == ST_RECV);
    DONE   = (state_q == ST_DONE);
    tready = (state_q == ST_RECV) && (count_q != DEPTH_C);
  end

  // Statistics and TLAST-position check
  always_comb begin
    recv_bytes_d = recv_bytes_q;
    sum_d        = sum_q;
    pkt_bytes_d  = pkt_bytes_q;
    pkt_count_d  = pkt_count_q;
    err_d        = err_q;
    if (go_start) begin
      recv_bytes_d = '0;
      sum_d        = '0;
      pkt_bytes_d  = '0;
      pkt_count_d  = '0;
      err_d        = 1'b0;
    end else if (accept) begin
      recv_bytes_d = (recv_bytes_q >= SAT_C) ? recv_bytes_q : recv_bytes_q + 32'd4;
      sum_d        = sum_q + S_AXIS_TDATA;
      if (last_err) err_d = 1'b1;
      if (S_AXIS_TLAST) begin
        // every TLAST resynchronises the packet position, even a misplaced one
        pkt_count_d = pkt_count_q + PKT_W'(1);
        pkt_bytes_d = '0;
      end else begin
        pkt_bytes_d = pkt_plus4;
      end
    end
  end

  // FWFT buffer bookkeeping; STOP flushes it
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (STOP) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = S_AXIS_TDATA;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      recv_bytes_q <= '0;
      sum_q        <= '0;
      pkt_bytes_q  <= '0;
      pkt_count_q  <= '0;
      err_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      recv_bytes_q <= recv_bytes_d;
      sum_q        <= sum_d;
      pkt_bytes_q  <= pkt_bytes_d;
      pkt_count_q  <= pkt_count_d;
      err_q        <= err_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      mem_q        <= mem_d;
    end
  end

`ifdef RNG_RX_ONES_EN
  logic [31:0] ones_count_q, ones_count_d;
  logic [5:0]  word_ones;

  // Popcount of the incoming word
  always_comb begin
    word_ones = '0;
    for (int i = 0; i < 32; i++) word_ones = word_ones + {5'd0, S_AXIS_TDATA[i]};
  end

  // Running ones count, cleared by GO, wraps mod 2^32
  always_comb begin
    ones_count_d = ones_count_q;
    if (go_start)    ones_count_d = '0;
    else if (accept) ones_count_d = ones_count_q + {26'd0, word_ones};
  end

  // Ones-count register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) ones_count_q <= '0;
    else     ones_count_q <= ones_count_d;
  end

  assign ONES_COUNT = ones_count_q;
`else
  assign ONES_COUNT = '0;
`endif

  assign S_AXIS_TREADY = tready;
  assign ERR_LAST      = err_q;
  assign RECV_BYTES    = recv_bytes_q;
  assign PKT_COUNT     = pkt_count_q;
  assign SUM_DATA      = sum_q;
  assign OUT_DATA      = mem_q[rd_ptr_q];
  assign OUT_VALID     = out_valid;

endmodule
